// File: rtl/wts_noise_channel_pkg.sv
// Shared types and helpers for the noise channel envelope and output stage.
package wts_noise_channel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSTAIN = 2'd1,
    DECAY   = 2'd2
  } env_state_t;

  // Envelope level is scaled by 8 to reach the +/-120 sample range.
  localparam int AMP_SHIFT = 3;

  function automatic logic [7:0] level_to_amp(input logic [3:0] level);
    return {4'b0000, level} << AMP_SHIFT;
  endfunction

endpackage

// File: rtl/wts_env_prescaler.sv
// Divides the active timing pulse down to envelope ticks.
module wts_env_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic active,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [PRESCALE_W-1:0] count;

  // Counter only moves on active pulses; clear wins over enable.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (active) begin
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + PRESCALE_W'(1);
      end
    end
  end

  assign tick = active && enable && !clear && (count == {PRESCALE_W{1'b1}});

endmodule

// File: rtl/wts_noise_channel.sv
// Noise channel: key-on decay envelope applied to the noise bit, giving a signed 8-bit sample.
module wts_noise_channel #(
  parameter int PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       active,
  input  logic       noise,
  input  logic       reg_key_on,
  input  logic       reg_key_off,
  input  logic [3:0] reg_volume,
  input  logic [3:0] reg_decay_rate,
  input  logic       reg_mute,
  output logic [7:0] sample,
  output logic       busy
);

  import wts_noise_channel_pkg::*;

  env_state_t state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] rate_cnt_q, rate_cnt_d;
  logic       on_pend, off_pend;
  logic       key_on_now, key_off_now;
  logic       presc_clear, presc_en, env_tick;
  logic [7:0] amp;

  // A key pulse landing on the active clk itself is consumed right away.
  assign key_on_now  = on_pend  | reg_key_on;
  assign key_off_now = off_pend | reg_key_off;

  // The prescaler runs only while actually decaying; any key event or other state zeroes it.
  assign presc_en    = (state_q == DECAY);
  assign presc_clear = key_on_now || key_off_now || (state_q != DECAY) || (reg_decay_rate == 4'd0);

  wts_env_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .nreset (nreset),
    .active (active),
    .clear  (presc_clear),
    .enable (presc_en),
    .tick   (env_tick)
  );

  // Capture key pulses between active pulses; they are dropped once consumed.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      on_pend  <= 1'b0;
      off_pend <= 1'b0;
    end else if (active) begin
      on_pend  <= 1'b0;
      off_pend <= 1'b0;
    end else begin
      on_pend  <= on_pend  | reg_key_on;
      off_pend <= off_pend | reg_key_off;
    end
  end

  // Envelope state, level and rate counter advance only on active pulses.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      level_q    <= 4'd0;
      rate_cnt_q <= 4'd0;
    end else if (active) begin
      state_q    <= state_d;
      level_q    <= level_d;
      rate_cnt_q <= rate_cnt_d;
    end
  end

  // Next envelope state: key-off beats key-on, key-on beats normal progression.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    rate_cnt_d = rate_cnt_q;
    if (key_off_now) begin
      state_d    = IDLE;
      level_d    = 4'd0;
      rate_cnt_d = 4'd0;
    end else if (key_on_now) begin
      level_d    = reg_volume;
      rate_cnt_d = 4'd0;
      if (reg_volume == 4'd0) begin
        state_d = IDLE;
      end else if (reg_decay_rate == 4'd0) begin
        state_d = SUSTAIN;
      end else begin
        state_d = DECAY;
      end
    end else begin
      case (state_q)
        IDLE: begin
          level_d    = 4'd0;
          rate_cnt_d = 4'd0;
        end
        SUSTAIN: begin
          if (reg_decay_rate != 4'd0) begin
            state_d    = DECAY;
            rate_cnt_d = 4'd0;
          end
        end
        DECAY: begin
          if (reg_decay_rate == 4'd0) begin
            state_d = SUSTAIN;
          end else if (env_tick) begin
            // ">=" lets a rate reduced below the running count still step on the next tick.
            if (rate_cnt_q >= reg_decay_rate - 4'd1) begin
              rate_cnt_d = 4'd0;
              level_d    = level_q - 4'd1;
              if (level_q == 4'd1) begin
                state_d = IDLE;
              end
            end else begin
              rate_cnt_d = rate_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          level_d    = 4'd0;
          rate_cnt_d = 4'd0;
        end
      endcase
    end
  end

  assign amp = level_to_amp(level_q);

  // Output stage samples the pre-update level so level changes appear one pulse later.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sample <= 8'd0;
    end else if (active) begin
      if (reg_mute) begin
        sample <= 8'd0;
      end else if (noise) begin
        sample <= amp;
      end else begin
        sample <= 8'd0 - amp;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_wts_noise_channel.sv
// Bench for wts_noise_channel: random noise against an arithmetic envelope model.
module tb_wts_noise_channel;

  logic       clk = 1'b0;
  logic       nreset;
  logic       active;
  logic       noise;
  logic       reg_key_on;
  logic       reg_key_off;
  logic [3:0] reg_volume;
  logic [3:0] reg_decay_rate;
  logic       reg_mute;
  logic [7:0] sample;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Model: level after k pulses of decay is vol - k/(256*rate), floored at zero.
  bit m_on;
  int m_vol;
  int m_rate;
  int m_elapsed;
  bit m_pend_on;
  bit m_pend_off;

  wts_noise_channel #(.PRESCALE_W(8)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .active         (active),
    .noise          (noise),
    .reg_key_on     (reg_key_on),
    .reg_key_off    (reg_key_off),
    .reg_volume     (reg_volume),
    .reg_decay_rate (reg_decay_rate),
    .reg_mute       (reg_mute),
    .sample         (sample),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic int m_level();
    int lvl;
    if (!m_on) return 0;
    if (m_rate == 0) return m_vol;
    lvl = m_vol - m_elapsed / (256 * m_rate);
    return (lvl < 0) ? 0 : lvl;
  endfunction

  task automatic model_clear();
    m_on = 0; m_vol = 0; m_rate = 0; m_elapsed = 0;
    m_pend_on = 0; m_pend_off = 0;
  endtask

  // One active pulse per six clks; optional key pulses follow on an idle clk.
  task automatic do_pulse(input bit kon, input bit koff, input int nz,
                          output logic [7:0] got_s, output logic [7:0] exp_s,
                          output logic got_b, output logic exp_b);
    int amp;
    @(negedge clk);
    active = 1'b1;
    noise  = (nz < 0) ? 1'($urandom) : 1'(nz);
    amp    = m_level() * 8;
    exp_s  = reg_mute ? 8'd0 : (noise ? 8'(amp) : 8'(-amp));
    if (m_pend_off) begin
      m_on = 0;
    end else if (m_pend_on) begin
      m_vol = int'(reg_volume); m_rate = int'(reg_decay_rate);
      m_elapsed = 0; m_on = (reg_volume != 4'd0);
    end else if (m_on && m_rate != 0) begin
      m_elapsed++;
    end
    if (m_level() == 0) m_on = 0;
    m_pend_on = 0; m_pend_off = 0;
    exp_b = (m_level() != 0);
    @(negedge clk);
    active = 1'b0;
    got_s = sample; got_b = busy;
    reg_key_on = kon; reg_key_off = koff;
    m_pend_on = kon; m_pend_off = koff;
    @(negedge clk);
    reg_key_on = 1'b0; reg_key_off = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] gs, es; logic gb, eb;
    nreset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      noise  = ~noise;
      active = (i % 6 == 0);
      tests++;
      if (sample !== 8'd0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_hold clk %0d: sample=%h busy=%b, want 00/0", i, sample, busy);
      end
    end
    @(negedge clk);
    active = 1'b0;
    nreset = 1'b1;
    model_clear();
    for (int i = 0; i < 10; i++) begin
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL post_reset sample p%0d: got %h want %h", i, gs, es); end
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL post_reset busy p%0d: got %b want %b", i, gb, eb); end
    end
  endtask

  task automatic test_sustain();
    logic [7:0] gs, es; logic gb, eb;
    reg_volume = 4'd15; reg_decay_rate = 4'd0; reg_mute = 1'b0;
    do_pulse(1, 0, -1, gs, es, gb, eb);
    for (int i = 0; i < 200; i++) begin
      do_pulse(0, 0, (i < 40) ? 1 : ((i < 80) ? 0 : -1), gs, es, gb, eb);
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL sustain sample p%0d: got %h want %h", i, gs, es); end
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL sustain busy p%0d: got %b want %b", i, gb, eb); end
      if (i == 39 || i == 79) begin
        tests++;
        if (gs !== ((i == 39) ? 8'h78 : 8'h88)) begin
          fails++; $display("[TB] FAIL sustain full_scale p%0d: got %h", i, gs);
        end
      end
    end
    do_pulse(0, 1, -1, gs, es, gb, eb);
    for (int i = 0; i < 4; i++) begin
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gs !== es || gb !== eb) begin
        fails++; $display("[TB] FAIL sustain key_off p%0d: got %h/%b want %h/%b", i, gs, gb, es, eb);
      end
    end
  endtask

  task automatic test_decay();
    logic [7:0] gs, es; logic gb, eb;
    reg_volume = 4'd4; reg_decay_rate = 4'd1; reg_mute = 1'b0;
    do_pulse(1, 0, -1, gs, es, gb, eb);
    for (int i = 0; i < 1040; i++) begin
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL decay sample p%0d: got %h want %h", i, gs, es); end
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL decay busy p%0d: got %b want %b", i, gb, eb); end
    end
    tests++;
    if (busy !== 1'b0 || sample !== 8'd0) begin
      fails++; $display("[TB] FAIL decay end_idle: sample=%h busy=%b, want 00/0", sample, busy);
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] gs, es; logic gb, eb;
    reg_volume = 4'd6; reg_decay_rate = 4'd2; reg_mute = 1'b0;
    do_pulse(1, 0, -1, gs, es, gb, eb);
    for (int i = 0; i < 1310; i++) begin
      if (i == 700) reg_volume = 4'd10;
      do_pulse(i == 700, i == 1300, -1, gs, es, gb, eb);
      if (i == 1300) reg_key_on = 1'b0;
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL retrigger sample p%0d: got %h want %h", i, gs, es); end
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL retrigger busy p%0d: got %b want %b", i, gb, eb); end
    end
  endtask

  task automatic test_key_on_off_same();
    logic [7:0] gs, es; logic gb, eb;
    reg_volume = 4'd7; reg_decay_rate = 4'd1;
    do_pulse(1, 0, -1, gs, es, gb, eb);
    do_pulse(0, 0, -1, gs, es, gb, eb);
    do_pulse(1, 1, -1, gs, es, gb, eb);
    for (int i = 0; i < 4; i++) begin
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL on_off_same busy p%0d: got %b want %b", i, gb, eb); end
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL on_off_same sample p%0d: got %h want %h", i, gs, es); end
    end
  endtask

  task automatic test_mute();
    logic [7:0] gs, es; logic gb, eb;
    reg_volume = 4'd9; reg_decay_rate = 4'd1; reg_mute = 1'b0;
    do_pulse(1, 0, -1, gs, es, gb, eb);
    for (int i = 0; i < 700; i++) begin
      reg_mute = (i >= 300 && i < 600);
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL mute sample p%0d: got %h want %h", i, gs, es); end
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL mute busy p%0d: got %b want %b", i, gb, eb); end
    end
    reg_mute = 1'b0;
    do_pulse(0, 1, -1, gs, es, gb, eb);
  endtask

  task automatic test_async_reset();
    logic [7:0] gs, es; logic gb, eb;
    reg_volume = 4'd12; reg_decay_rate = 4'd1; reg_mute = 1'b0;
    do_pulse(1, 0, -1, gs, es, gb, eb);
    for (int i = 0; i < 400; i++) begin
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gs !== es || gb !== eb) begin
        fails++; $display("[TB] FAIL pre_reset p%0d: got %h/%b want %h/%b", i, gs, gb, es, eb);
      end
    end
    do_pulse(1, 0, -1, gs, es, gb, eb);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    tests++;
    if (sample !== 8'd0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL async_reset immediate: sample=%h busy=%b, want 00/0", sample, busy);
    end
    model_clear();
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_pulse(0, 0, -1, gs, es, gb, eb);
      tests++;
      if (gs !== es) begin fails++; $display("[TB] FAIL stale_key_on sample p%0d: got %h want %h", i, gs, es); end
      tests++;
      if (gb !== eb) begin fails++; $display("[TB] FAIL stale_key_on busy p%0d: got %b want %b", i, gb, eb); end
    end
  endtask

  task automatic test_random();
    logic [7:0] gs, es; logic gb, eb;
    for (int seg = 0; seg < 8; seg++) begin
      reg_volume     = 4'($urandom_range(0, 15));
      reg_decay_rate = 4'($urandom_range(0, 2));
      do_pulse(1, 0, -1, gs, es, gb, eb);
      for (int i = 0; i < 200; i++) begin
        reg_mute = ($urandom_range(0, 7) == 0);
        do_pulse(0, ($urandom_range(0, 99) == 0), -1, gs, es, gb, eb);
        tests++;
        if (gs !== es) begin fails++; $display("[TB] FAIL random sample s%0d p%0d: got %h want %h", seg, i, gs, es); end
        tests++;
        if (gb !== eb) begin fails++; $display("[TB] FAIL random busy s%0d p%0d: got %b want %b", seg, i, gb, eb); end
      end
    end
  endtask

  initial begin
    nreset = 1'b0; active = 1'b0; noise = 1'b0;
    reg_key_on = 1'b0; reg_key_off = 1'b0; reg_mute = 1'b0;
    reg_volume = 4'd0; reg_decay_rate = 4'd0;
    model_clear();
    test_reset();
    test_sustain();
    test_decay();
    test_retrigger();
    test_key_on_off_same();
    test_mute();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
